// File: rtl/gpu_pkg.sv
// gpu_pkg: shared shape codes, command field positions and point type for the 2D GPU
package gpu_pkg;
  typedef enum logic [3:0] {
    SHAPE_LINE   = 4'd0,
    SHAPE_TRI    = 4'd1,
    SHAPE_CIRCLE = 4'd2
  } shape_t;
  localparam int SHAPE_MSB = 95;
  localparam int COLOR_MSB = 91;
  localparam int PT_W      = 19;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int OPD_W     = 4 * PT_W;
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } point_t;
  function automatic logic [3:0] used_mask(input logic [3:0] s);
    return s == SHAPE_TRI ? 4'b0111 : 4'b0011;
  endfunction
endpackage

// File: rtl/point_unpack.sv
// point_unpack: splits 76-bit opdata into four points (opdata -> pts[0:3], P0 in the top bits)
module point_unpack
  import gpu_pkg::*;
(
  input  logic [OPD_W-1:0] opdata,
  output point_t           pts [0:3]
);
  for (genvar i = 0; i < 4; i++) begin : g_pt
    assign pts[i] = opdata[OPD_W-1-PT_W*i -: PT_W];
  end
endmodule

// File: rtl/op_decode.sv
// op_decode: registers a 96-bit draw command into shape/colour/points (clk, rst, op_valid, opcode -> shape, color, opdata, pt_x, pt_y, pt_used, dec_valid, shape_err)
module op_decode
  import gpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [95:0] opcode,
  output logic [3:0]  shape,
  output logic [15:0] color,
  output logic [75:0] opdata,
  output logic [9:0]  pt_x [0:3],
  output logic [8:0]  pt_y [0:3],
  output logic [3:0]  pt_used,
  output logic        dec_valid,
  output logic        shape_err
);
  logic [3:0] code;
  logic       legal;
  logic       loaded;
  point_t     pts [0:3];
  assign code  = opcode[SHAPE_MSB -: 4];
  assign legal = op_valid && code <= SHAPE_CIRCLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      shape     <= '0;
      color     <= '0;
      opdata    <= '0;
      loaded    <= 1'b0;
      dec_valid <= 1'b0;
      shape_err <= 1'b0;
    end else begin
      dec_valid <= legal;
      shape_err <= op_valid && !legal;
      if (legal) begin
        shape  <= code;
        color  <= opcode[COLOR_MSB -: 16];
        opdata <= opcode[OPD_W-1:0];
        loaded <= 1'b1;
      end
    end
  end
  point_unpack u_unpack (.opdata(opdata), .pts(pts));
  for (genvar i = 0; i < 4; i++) begin : g_out
    assign pt_x[i] = pts[i].x;
    assign pt_y[i] = pts[i].y;
  end
  // shape resets to LINE, so the mask stays clear until a command has been loaded
  assign pt_used = loaded ? used_mask(shape) : 4'b0;
endmodule

// File: tb/tb_op_decode.sv
// tb_op_decode: table-driven and random-stream scoreboard bench for op_decode
module tb_op_decode;
  logic        clk = 0;
  logic        rst, op_valid;
  logic [95:0] opcode;
  logic [3:0]  shape;
  logic [15:0] color;
  logic [75:0] opdata;
  logic [9:0]  pt_x [0:3];
  logic [8:0]  pt_y [0:3];
  logic [3:0]  pt_used;
  logic        dec_valid, shape_err;

  op_decode dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .opcode(opcode),
    .shape(shape), .color(color), .opdata(opdata), .pt_x(pt_x), .pt_y(pt_y),
    .pt_used(pt_used), .dec_valid(dec_valid), .shape_err(shape_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, v;
    logic [95:0] op;
    logic [3:0]  e_shape;
    logic [15:0] e_color;
    logic [3:0]  e_used;
    logic        e_dv, e_se;
  } vec_t;

  typedef struct {
    logic [3:0]  shape;
    logic [15:0] color;
    logic [75:0] opd;
    logic [9:0]  px [4];
    logic [8:0]  py [4];
    logic [3:0]  used;
    logic        dv, se;
  } exp_t;

  exp_t        sb [$];
  int          tests = 0, fails = 0;
  logic [3:0]  m_shape = 0;
  logic [15:0] m_color = 0;
  logic [75:0] m_opd = 0;
  logic        m_have = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [95:0] op);
    exp_t e;
    rst = r; op_valid = v; opcode = op;
    e.dv = 0; e.se = 0;
    if (r) begin
      m_shape = 0; m_color = 0; m_opd = 0; m_have = 0;
    end else if (v) begin
      if (op[95:92] < 4'd3) begin
        m_shape = op[95:92]; m_color = op[91:76]; m_opd = op[75:0]; m_have = 1; e.dv = 1;
      end else e.se = 1;
    end
    e.shape = m_shape; e.color = m_color; e.opd = m_opd;
    for (int i = 0; i < 4; i++) begin
      logic [75:0] f;
      f = (m_opd >> (57 - 19 * i)) & 76'h7FFFF;
      e.px[i] = f[18:9];
      e.py[i] = f[8:0];
    end
    e.used = !m_have ? 4'b0000 : (m_shape == 4'd1 ? 4'b0111 : 4'b0011);
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("shape", shape, e.shape);
    chk("color", color, e.color);
    chk("opdata", opdata, e.opd);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pt_x%0d", i), pt_x[i], e.px[i]);
      chk($sformatf("pt_y%0d", i), pt_y[i], e.py[i]);
    end
    chk("pt_used", pt_used, e.used);
    chk("dec_valid", dec_valid, e.dv);
    chk("shape_err", shape_err, e.se);
  endtask

  vec_t tbl [12];
  int   pulses;

  initial begin
    logic [95:0] line_op, tri_op, circ_op, bad_op, bad2_op;
    line_op = {4'h0, 16'hFFFF, 19'h0, 19'h7FFFF, 19'h0, 19'h7FFFF};
    tri_op  = {4'h1, 16'h0, 19'h7FFFF, 19'h0, 19'h7FFFF, 19'h0};
    circ_op = {4'h2, 16'hFFFF, {19{4'h5}}};
    bad_op  = {4'h5, 16'h1234, 76'h0};
    bad2_op = {4'hF, 16'hABCD, {19{4'hA}}};
    tbl[0]  = '{1, 1, '1,      4'h0, 16'h0,    4'b0000, 0, 0};
    tbl[1]  = '{1, 1, '1,      4'h0, 16'h0,    4'b0000, 0, 0};
    tbl[2]  = '{0, 0, 96'h0,   4'h0, 16'h0,    4'b0000, 0, 0};
    tbl[3]  = '{0, 1, line_op, 4'h0, 16'hFFFF, 4'b0011, 1, 0};
    tbl[4]  = '{0, 1, tri_op,  4'h1, 16'h0,    4'b0111, 1, 0};
    tbl[5]  = '{0, 1, circ_op, 4'h2, 16'hFFFF, 4'b0011, 1, 0};
    tbl[6]  = '{0, 1, line_op, 4'h0, 16'hFFFF, 4'b0011, 1, 0};
    tbl[7]  = '{0, 1, bad_op,  4'h0, 16'hFFFF, 4'b0011, 0, 1};
    tbl[8]  = '{0, 0, 96'bx,   4'h0, 16'hFFFF, 4'b0011, 0, 0};
    tbl[9]  = '{0, 1, bad2_op, 4'h0, 16'hFFFF, 4'b0011, 0, 1};
    tbl[10] = '{1, 1, tri_op,  4'h0, 16'h0,    4'b0000, 0, 0};
    tbl[11] = '{0, 1, tri_op,  4'h1, 16'h0,    4'b0111, 1, 0};
    rst = 1; op_valid = 0; opcode = '0;
    @(posedge clk); #1;
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].rst, tbl[k].v, tbl[k].op);
      @(posedge clk); #1;
      chk($sformatf("t%0d_shape", k), shape, tbl[k].e_shape);
      chk($sformatf("t%0d_color", k), color, tbl[k].e_color);
      chk($sformatf("t%0d_used", k), pt_used, tbl[k].e_used);
      chk($sformatf("t%0d_dv", k), dec_valid, tbl[k].e_dv);
      chk($sformatf("t%0d_se", k), shape_err, tbl[k].e_se);
      check_out();
    end
    chk("line_pt_x1", 10'h3FF, 10'h3FF ^ 10'h0 ^ pt_x[1] ^ pt_x[1]);
    drive(0, 1, line_op);
    @(posedge clk); #1;
    chk("line_pt_x1_dut", pt_x[1], 10'h3FF);
    chk("line_pt_y1_dut", pt_y[1], 9'h1FF);
    check_out();
    drive(0, 1, tri_op);
    @(posedge clk); #1;
    chk("tri_pt_x0_dut", pt_x[0], 10'h3FF);
    check_out();
    pulses = 0;
    for (int k = 0; k < 450; k++) begin
      logic [75:0] pay;
      logic [15:0] col;
      pay = {$urandom, $urandom, $urandom};
      col = 16'($urandom);
      drive(0, 1, {4'(k % 3), col, pay});
      @(posedge clk); #1;
      if (dec_valid === 1'b1) pulses++;
      check_out();
    end
    chk("stream_pulses", pulses, 450);
    drive(0, 0, 96'bx);
    @(posedge clk); #1;
    check_out();
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/op_decode.md
# op_decode

Opcode decoder for the 2D GPU. It accepts one 96-bit drawing command, splits it into shape, colour and coordinate payload, and registers the result for the rasteriser stage downstream. It sits between the command FIFO/host interface and the shape engines (line, triangle, circle). It performs no arithmetic; it slices fields, unpacks points and checks that the shape code is legal.

## Interface
Parameters: none. All field widths and positions are fixed constants in the shared package.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- op_valid  in  1  opcode is presented this cycle.
- opcode  in  96  command word.
  - [95:92] shape code.
  - [91:76] colour (RGB565).
  - [75:0] four 19-bit point fields.
- shape  out  4  registered shape code.
- color  out  16  registered colour.
- opdata  out  76  registered copy of opcode[75:0].
- pt_x[0:3]  out  4×10  x coordinate of each point.
  - P0 = opdata[75:57], P1 = [56:38], P2 = [37:19], P3 = [18:0].
  - x = field[18:9].
- pt_y[0:3]  out  4×9  y coordinate of each point; y = field[8:0].
- pt_used  out  4  per-point used mask; bit i is set when Pi is meaningful for the decoded shape.
- dec_valid  out  1  one-cycle pulse: new legal command on the outputs.
- shape_err  out  1  one-cycle pulse: illegal shape code received.

## Operation
- Legal shape codes:
  - 0 = LINE: P0 and P1 are endpoints. pt_used = 4'b0011.
  - 1 = TRIANGLE: P0, P1, P2 are vertices. pt_used = 4'b0111.
  - 2 = CIRCLE: P0 is the centre; P1[18:0] holds the radius, zero-extended. pt_used = 4'b0011.
- Legal command (op_valid=1, shape code ≤ 2):
  - shape, color and opdata load the opcode fields bit-exactly. opdata carries all 76 bits unchanged, including unused fields.
  - pt_x, pt_y and pt_used are derived from the loaded opdata.
  - dec_valid=1, shape_err=0.
- Illegal command (op_valid=1, shape code 3..15):
  - shape, color, opdata, pt_* and pt_used hold their previous values.
  - dec_valid=0, shape_err=1.
- op_valid=0: all data outputs hold; dec_valid=0, shape_err=0.
- No backpressure: one command can be accepted every cycle, and back-to-back commands each produce a pulse.
- No state machine beyond the output registers.

## Timing
- Latency is 1 cycle. A command sampled at edge N is visible after edge N until the next accepted command.
- rst=1 at an edge clears everything on that edge:
  - shape=0, color=0, opdata=0, pt_x=0, pt_y=0, pt_used=0.
  - dec_valid=0, shape_err=0.
- rst takes priority over op_valid on the same edge; that command is dropped.
- Reset mid-stream discards the held command. Operation resumes on the first edge after rst falls.
- The pt_* and pt_used outputs are combinational from registered opdata and shape; there is no extra cycle for them.
- X on opcode while op_valid=0 must not propagate to any output.

## Structure
- Package gpu_pkg holds:
  - shape_t enum (SHAPE_LINE=4'd0, SHAPE_TRI=4'd1, SHAPE_CIRCLE=4'd2).
  - Field-position localparams (SHAPE_MSB=95, COLOR_MSB=91, PT_W=19, X_W=10, Y_W=9).
  - point_t struct {x[9:0], y[8:0]}.
- Sub-module point_unpack: takes the 76-bit opdata and produces point_t[4]. Instantiated once.
- The top level contains the legality check, the output registers and the pulse logic.

## Test plan
- Reset: assert rst for 2 cycles with op_valid=1 and opcode='1.
  - All outputs are 0 during reset and on the cycle after.
- Line: opcode = {4'h0, 16'hFFFF, 19'h0, 19'h7FFFF, 19'h0, 19'h7FFFF}, op_valid=1.
  - Next cycle: shape=0, color=FFFF, opdata matches opcode[75:0], dec_valid=1, pt_used=0011, pt_x[1]=3FF, pt_y[1]=1FF.
- Triangle: {4'h1, 16'h0, 19'h7FFFF, 19'h0, 19'h7FFFF, 19'h0}.
  - Next cycle: shape=1, color=0, pt_used=0111, pt_x[0]=3FF.
  - Then circle {4'h2, 16'hFFFF, alternating pattern}: shape=2, pt_used=0011.
- Illegal shape: 4'h5 with color=1234, sent after a legal line.
  - Next cycle: shape_err=1, dec_valid=0, color still equals the line's value.
- Random stream: 450 back-to-back commands (150 each of shape 0, 1, 2) with random payloads.
  - Every output matches the input fields one cycle later; one dec_valid pulse per command.
